// File: rtl/regfile_seq_ctrl.sv
// Multicycle control sequencer for the lab CPU: fetch, decode, execute,
// memory and write-back steps driving register file, ALU, PC and data memory.
module regfile_seq_ctrl #(
    parameter int         TIMEOUT_CYC = 255,
    parameter logic [3:0] HALT_OP     = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [15:0] ir,
    output logic        pc_inc,
    output logic        pc_load,
    input  logic        alu_zero,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        wb_sel_mem,
    output logic        reg_write,
    output logic        IType,
    output logic        halted,
    output logic        fault
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [15:0]    r_ir;
    logic [CW-1:0]  r_cnt;
    logic           r_fault;
    logic [3:0]     w_op;
    logic           w_wait;
    logic           w_tmo;
    logic           w_alu_phase;

    assign w_op   = r_ir[15:12];
    assign w_wait = ((r_state == S_FETCH) && !imem_ready) ||
                    ((r_state == S_MEM) && !dmem_ready);
    assign w_tmo  = w_wait && (r_cnt == TMO_LAST);
    assign w_alu_phase = (r_state == S_EXEC) || (r_state == S_MEM) ||
                         (r_state == S_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && imem_ready)
                r_ir <= imem_rdata;
            // Wait counter only runs while a request is outstanding
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_wait)
                r_cnt <= r_cnt + CW'(1);
            if (w_tmo)
                r_fault <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (imem_ready)
                    w_next = S_DECODE;
                else if (w_tmo)
                    w_next = S_HALT;
            end
            S_DECODE: begin
                if (w_op == HALT_OP)
                    w_next = S_HALT;
                else if (w_op inside {4'h0, 4'hD, 4'hE})
                    w_next = S_FETCH;
                else
                    w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_op inside {4'h9, 4'hA})
                    w_next = S_MEM;
                else if (w_op inside {[4'h1:4'h8]})
                    w_next = S_WB;
                else
                    w_next = S_FETCH;
            end
            S_MEM: begin
                if (dmem_ready)
                    w_next = (w_op == 4'h9) ? S_WB : S_FETCH;
                else if (w_tmo)
                    w_next = S_HALT;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_op      = 4'h0;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        wb_sel_mem  = 1'b0;
        reg_write   = 1'b0;
        IType       = 1'b0;
        halted      = 1'b0;
        if (w_alu_phase) begin
            if (w_op inside {[4'h1:4'h7]}) begin
                alu_op = w_op;
            end else if (w_op inside {4'h8, 4'h9, 4'hA}) begin
                alu_op      = 4'h1;
                alu_src_imm = 1'b1;
            end else if (w_op == 4'hB) begin
                alu_op = 4'h2;
            end
        end
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                pc_inc   = imem_ready;
            end
            S_EXEC: begin
                pc_load = (w_op == 4'hC) || ((w_op == 4'hB) && alu_zero);
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (w_op == 4'hA);
                wb_sel_mem = (w_op == 4'h9);
            end
            S_WB: begin
                reg_write  = 1'b1;
                IType      = (w_op == 4'h8) || (w_op == 4'h9);
                wb_sel_mem = (w_op == 4'h9);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign ir    = r_ir;
    assign fault = r_fault;

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
Multicycle control FSM that sequences the 16x16 register file, ALU and memories of the lab CPU. It fetches a 16-bit instruction over a req/ready handshake and decodes opcode/fields. It steps through FETCH/DECODE/EXEC/MEM/WB and drives the register-file strobes (reg_write, IType) plus ALU, PC and data-memory controls. It is the only source of reg_write in the core.

Parameters:
TIMEOUT_CYC, 255, max cycles a memory req may wait for ready before fault
HALT_OP, 4'hF, opcode that enters HALT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_rdata  in  16  instruction from instruction memory
imem_ready  in  1  instruction data valid this cycle
imem_req  out  1  instruction fetch request
ir  out  16  latched instruction register
pc_inc  out  1  PC += 1 pulse
pc_load  out  1  PC <= branch/jump target pulse
alu_zero  in  1  ALU zero flag (combinational from datapath)
alu_op  out  4  ALU function select
alu_src_imm  out  1  ALU B operand = zero-extended ir[3:0]
dmem_ready  in  1  data memory access complete
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
wb_sel_mem  out  1  write_data source: 1 = memory, 0 = ALU
reg_write  out  1  register file write strobe
IType  out  1  register file I-type destination select (writes RS1 field)
halted  out  1  core stopped
fault  out  1  memory timeout occurred (sticky)

Behaviour:
- Reset (async, rst=1): state=FETCH, ir=0, cycle counter=0, fault=0. All outputs 0 except imem_req, which is 1 combinationally in FETCH.
- Fields: op=ir[15:12], RA=ir[11:8], RS1=ir[7:4], RS2/imm=ir[3:0].
- Opcodes:
  - 0 NOP.
  - 1..7 R-type ALU, alu_op=op.
  - 8 ADDI, I-type, alu_op=1, alu_src_imm=1.
  - 9 LW, I-type, dest RS1.
  - A SW.
  - B BEQ.
  - C JMP.
  - D,E NOP.
  - HALT_OP.
- FETCH:
  - imem_req=1 until imem_ready.
  - On ready: ir<=imem_rdata, pc_inc pulse in that same cycle, go to DECODE.
- DECODE (1 cycle):
  - op=HALT_OP -> HALT.
  - NOP/D/E -> FETCH.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - alu_op and alu_src_imm valid during EXEC, MEM and WB.
  - R-type/ADDI -> WB.
  - LW/SW -> MEM; address is the ALU result of RS1+imm, so alu_op=1 and alu_src_imm=1.
  - BEQ: alu_op=2 (SUB). pc_load=1 iff alu_zero, then FETCH.
  - JMP: pc_load=1, then FETCH.
- MEM:
  - dmem_req=1, dmem_we=(op==A), held stable until dmem_ready.
  - On ready: LW -> WB, SW -> FETCH.
- WB (1 cycle):
  - reg_write=1 for exactly one cycle.
  - IType=1 for ADDI/LW, 0 for R-type.
  - wb_sel_mem=1 for LW, held through MEM and WB.
- HALT: halted=1, all strobes 0. Only rst exits.
- Latency with zero-wait memory (ready in the req cycle):
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/JMP: 3 cycles.
  - NOP: 2 cycles.
- Timeout:
  - Counter counts cycles in FETCH or MEM while ready=0 and resets on state change.
  - Reaching TIMEOUT_CYC sets fault=1 and moves to HALT.
- Ready arriving in a state that did not request it is ignored.
- reg_write, pc_inc and pc_load are never asserted in the same cycle as each other.
- rst asserted mid-instruction aborts it immediately. No write strobe is issued on or after the reset edge.

Test Plan:
- Reset mid-WB of an ADD -> reg_write drops at once, state=FETCH, imem_req=1, halted=0, fault=0.
- Fetch 16'h1123 (ADD RA=1,RS1=2,RS2=3), ready in the req cycle -> pc_inc in cycle 0, alu_op=1 in cycles 2-3, reg_write=1 IType=0 only in cycle 3, back in FETCH at cycle 4.
- Fetch 16'h9045 (LW), dmem_ready delayed 3 cycles -> dmem_req/dmem_we=0 held 4 cycles, then one WB cycle with reg_write=1, IType=1, wb_sel_mem=1.
- 16'hB012 (BEQ) with alu_zero=1 -> pc_load pulse in EXEC, no reg_write. Repeat with alu_zero=0 -> no pc_load.
- 16'hF000 -> halted=1 after DECODE; further imem_ready pulses produce no strobes until rst.
- Hold imem_ready=0 with TIMEOUT_CYC=8 -> fault=1 and halted=1 after 8 cycles in FETCH.
